// File: rtl/updown_count_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// updown_count_ctrl_pkg
// Shared definitions for the up/down counter sequencer:
//   - state_t     : controller FSM states
//   - MODE_*      : command mode encodings (2'b11 behaves as MODE_SHORT)
//   - mod_dist()  : modular distance "to_val - from_val" on a given bit width
// -----------------------------------------------------------------------------
package updown_count_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SHORT = 2'b00;
    localparam logic [1:0] MODE_UP    = 2'b01;
    localparam logic [1:0] MODE_DOWN  = 2'b10;

    // Widest counter the distance helper supports.
    localparam int MAX_W = 16;

    // Distance travelled counting upward from from_val to to_val, modulo
    // 2^width. Callers zero-extend their operands to MAX_W bits and truncate
    // the result back to their own width.
    function automatic logic [MAX_W-1:0] mod_dist(
        input logic [MAX_W-1:0] from_val,
        input logic [MAX_W-1:0] to_val,
        input int unsigned      width
    );
        logic [MAX_W-1:0] mask;
        mask = '1;
        mask = mask >> (MAX_W - width);
        return (to_val - from_val) & mask;
    endfunction

endpackage

// File: rtl/updown_cnt.sv
// -----------------------------------------------------------------------------
// updown_cnt
// W-bit up/down counter register, wrapping modulo 2^W.
// Ports:
//   clk  : clock, all updates on the rising edge
//   CLR  : synchronous active-high clear (q <= 0)
//   en   : step enable; q holds when low
//   up   : step direction, 1 = increment, 0 = decrement
//   q    : current count
// -----------------------------------------------------------------------------
module updown_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         CLR,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (CLR) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= up ? (r_q + W'(1)) : (r_q - W'(1));
        end
    end

    assign q = r_q;

endmodule

// File: rtl/updown_count_ctrl.sv
// -----------------------------------------------------------------------------
// updown_count_ctrl
// Sequencer that owns an up/down counter. A target command is accepted over a
// valid/ready handshake; the counter is then stepped once per clock (shortest
// path, or forced up/down) until it reaches the target, after which a
// one-cycle done pulse is issued. abort ends a run early.
// Ports:
//   clk        : clock
//   CLR        : synchronous active-high reset, overrides everything
//   cmd_valid  : command present
//   cmd_ready  : command can be accepted (IDLE only)
//   cmd_target : requested final count
//   cmd_mode   : 00 shortest, 01 force up, 10 force down, 11 as 00
//   abort      : stop an in-progress run
//   q          : current counter value
//   dir        : step direction, 1 = up
//   busy       : high while running
//   done       : one-cycle completion pulse
//   aborted    : qualifies done; 1 when the run was ended by abort
//   steps      : steps taken in the current or last run
// -----------------------------------------------------------------------------
module updown_count_ctrl
    import updown_count_ctrl_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         CLR,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_target,
    input  logic [1:0]   cmd_mode,
    input  logic         abort,
    output logic [W-1:0] q,
    output logic         dir,
    output logic         busy,
    output logic         done,
    output logic         aborted,
    output logic [W:0]   steps
);

    // One full lap: 2^W steps, needs the extra bit of the distance width.
    localparam logic [W:0] FULL_LAP = {1'b1, {W{1'b0}}};

    state_t       r_state;
    state_t       w_state_next;

    logic         r_dir;
    logic [W:0]   r_remaining;
    logic [W:0]   r_steps;
    logic         r_aborted;

    logic         w_accept;
    logic [W-1:0] w_up_dist;
    logic [W-1:0] w_dn_dist;
    logic [W:0]   w_dist;
    logic         w_dir_cmd;
    logic         w_arrive;
    logic         w_stop;
    logic         w_en;

    // ---------------------------------------------------------------- datapath
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_up_dist = W'(mod_dist(MAX_W'(q), MAX_W'(cmd_target), W));
    assign w_dn_dist = W'(mod_dist(MAX_W'(cmd_target), MAX_W'(q), W));

    // Direction and distance for the command on the input pins.
    always_comb begin
        w_dir_cmd = 1'b1;
        w_dist    = '0;
        case (cmd_mode)
            MODE_UP: begin
                w_dir_cmd = 1'b1;
                w_dist    = (w_up_dist == '0) ? FULL_LAP : {1'b0, w_up_dist};
            end
            MODE_DOWN: begin
                w_dir_cmd = 1'b0;
                w_dist    = (w_dn_dist == '0) ? FULL_LAP : {1'b0, w_dn_dist};
            end
            default: begin
                // Shortest path; equal distances resolve upward.
                if (w_up_dist <= w_dn_dist) begin
                    w_dir_cmd = 1'b1;
                    w_dist    = {1'b0, w_up_dist};
                end else begin
                    w_dir_cmd = 1'b0;
                    w_dist    = {1'b0, w_dn_dist};
                end
            end
        endcase
    end

    // The step on the edge where only one remains is the arrival; an abort on
    // that same edge loses to it.
    assign w_arrive = (r_remaining == (W+1)'(1));
    assign w_stop   = abort && !w_arrive;
    assign w_en     = (r_state == RUN) && !w_stop;

    always_ff @(posedge clk) begin
        if (CLR) begin
            r_dir       <= 1'b1;
            r_remaining <= '0;
            r_steps     <= '0;
            r_aborted   <= 1'b0;
        end else if (w_accept) begin
            r_dir       <= w_dir_cmd;
            r_remaining <= w_dist;
            r_steps     <= '0;
            r_aborted   <= 1'b0;
        end else if (r_state == RUN) begin
            if (w_stop) begin
                r_aborted <= 1'b1;
            end else begin
                r_steps     <= r_steps + (W+1)'(1);
                r_remaining <= r_remaining - (W+1)'(1);
            end
        end
    end

    updown_cnt #(
        .W (W)
    ) u_cnt (
        .clk (clk),
        .CLR (CLR),
        .en  (w_en),
        .up  (r_dir),
        .q   (q)
    );

    // --------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (CLR) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_dist == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_arrive || abort) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == IDLE);
        busy      = (r_state == RUN);
        done      = (r_state == DONE);
    end

    assign dir     = r_dir;
    assign steps   = r_steps;
    assign aborted = r_aborted;

endmodule

// File: tb/tb_updown_count_ctrl.sv
module tb_updown_count_ctrl;

    localparam int W = 2;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         CLR;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_target;
    logic [1:0]   cmd_mode;
    logic         abort;
    logic [W-1:0] q;
    logic         dir;
    logic         busy;
    logic         done;
    logic         aborted;
    logic [W:0]   steps;

    int n_err = 0;
    int n_chk = 0;
    int m_q   = 0;

    always #5 clk = ~clk;

    updown_count_ctrl #(.W(W)) dut (
        .clk        (clk),
        .CLR        (CLR),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_mode   (cmd_mode),
        .abort      (abort),
        .q          (q),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .steps      (steps)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issues one command and follows it cycle by cycle through to IDLE.
    // Entered and left at a falling edge with the block idle.
    // abort_at: step index k at which abort is driven (-1 = never).
    task automatic do_cmd(input int t, input int mode, input int abort_at,
                          input bit hold, input bit idle_abort);
        int up_d, dn_d, d, k, dirm, q0;
        bit ab, fin;
        up_d = (t - m_q + M) % M;
        dn_d = (m_q - t + M) % M;
        if (mode == 1) begin
            dirm = 1; d = (up_d == 0) ? M : up_d;
        end else if (mode == 2) begin
            dirm = 0; d = (dn_d == 0) ? M : dn_d;
        end else begin
            dirm = (up_d <= dn_d) ? 1 : 0;
            d    = (up_d <= dn_d) ? up_d : dn_d;
        end
        q0 = m_q;

        chk("idle_ready", cmd_ready, 1);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        cmd_valid  = 1'b1;
        cmd_target = W'(t);
        cmd_mode   = 2'(mode);
        abort      = idle_abort;
        @(negedge clk);

        if (hold) begin
            cmd_target = W'(t + 1 + $urandom_range(0, M - 2));
            cmd_mode   = 2'($urandom_range(0, 3));
        end else begin
            cmd_valid = 1'b0;
        end

        k  = 0;
        ab = 0;
        fin = (d == 0);
        while (!fin) begin
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk("run_ready", cmd_ready, 0);
            chk("run_q", q, m_q);
            chk("run_steps", steps, k);
            chk("run_dir", dir, dirm);
            abort = (k == abort_at);
            @(negedge clk);
            if (abort && (d - k) != 1) begin
                ab  = 1;
                fin = 1;
            end else begin
                m_q = (m_q + (dirm != 0 ? 1 : M - 1)) % M;
                k++;
                if (k == d) fin = 1;
            end
        end

        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_ready", cmd_ready, 0);
        chk("done_aborted", aborted, ab);
        chk("done_steps", steps, k);
        chk("done_q", q, m_q);
        chk("done_dir", dir, dirm);
        abort     = 1'($urandom_range(0, 1));
        cmd_valid = 1'b0;
        @(negedge clk);

        abort = 1'b0;
        chk("post_done", done, 0);
        chk("post_ready", cmd_ready, 1);
        chk("post_busy", busy, 0);
        chk("post_steps", steps, k);
        chk("post_aborted", aborted, ab);
        chk("post_q", q, m_q);
        $display("cmd q0=%0d target=%0d mode=%0d dist=%0d abort_at=%0d -> q=%0d steps=%0d aborted=%0d",
                 q0, t, mode, d, abort_at, m_q, k, ab);
    endtask

    initial begin
        CLR        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_target = '0;
        cmd_mode   = 2'b00;
        abort      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_q", q, 0);
        chk("rst_dir", dir, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_steps", steps, 0);
        chk("rst_ready", cmd_ready, 1);
        CLR = 1'b0;
        m_q = 0;
        @(negedge clk);
        $display("reset released q=%0d", q);

        // Directed cases
        do_cmd(2, 0, -1, 0, 0);   // tie from 0 -> up, 1,2
        do_cmd(1, 0, -1, 1, 0);   // down one, cmd_valid held during run
        do_cmd(3, 1, -1, 0, 0);   // forced up 2,3
        do_cmd(3, 2, -1, 0, 0);   // forced down full lap 2,1,0,3
        do_cmd(3, 0, -1, 1, 1);   // zero distance, abort in IDLE/DONE ignored
        do_cmd(0, 0, -1, 0, 0);   // 3 -> 0 short path up
        do_cmd(1, 2, 1, 0, 0);    // down 3,2,1 aborted after first step
        do_cmd(0, 1, -1, 0, 0);   // 3 -> 0
        do_cmd(2, 2, 1, 1, 0);    // abort coincides with arrival

        // Random commands
        for (int i = 0; i < 30; i++) begin
            int a;
            a = int'($urandom_range(0, 5)) - 1;
            do_cmd(int'($urandom_range(0, M - 1)), int'($urandom_range(0, 3)), a,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a run
        do_cmd(0, 1, -1, 0, 0);
        cmd_valid  = 1'b1;
        cmd_target = 2'd2;
        cmd_mode   = 2'b00;
        @(negedge clk);
        cmd_target = 2'd3;        // held, must be ignored
        chk("clr_run_q0", q, 0);
        chk("clr_run_ready", cmd_ready, 0);
        @(negedge clk);
        chk("clr_run_q1", q, 1);
        chk("clr_run_busy", busy, 1);
        CLR       = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        CLR = 1'b0;
        m_q = 0;
        chk("clr_q", q, 0);
        chk("clr_ready", cmd_ready, 1);
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);
        chk("clr_steps", steps, 0);
        chk("clr_dir", dir, 1);
        chk("clr_aborted", aborted, 0);
        @(negedge clk);
        chk("clr_no_done", done, 0);
        chk("clr_q_hold", q, 0);
        $display("clr mid-run -> q=%0d ready=%0d", q, cmd_ready);

        do_cmd(3, 0, -1, 0, 0);   // works after reset: tie? 0->3 down one

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
